heartbeat_scheduler: RTL
========================

Name: heartbeat_scheduler

Overview:
- Per-host session timer and outbound-message scheduler for the FIX engine.
- Tracks the time since the last message was sent to and received from each connected host.
- When a host's send interval expires, it requests a Heartbeat from the message creation path; one request is outstanding at a time, and pending hosts are served round-robin.
- When a host's receive interval expires, it raises a timeout pulse toward the session manager, which drives that manager's timeout input.

Parameters:
- HOST_ADDR_WIDTH, 2: host address width; number of tracked hosts N = 2**HOST_ADDR_WIDTH.
- TICK_DIV, 1000: clk cycles per timer tick (one logical second).
- HB_INT, 30: ticks without a send before a Heartbeat is requested; legal range 1..254.
- RX_TIMEOUT, 36: ticks without a receive before a timeout is flagged; legal range HB_INT+1..255.
- HB_TYPE, 4'd0: message-type code presented on msg_type_o for a Heartbeat.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- connected_i  in  1  one-cycle pulse: the host on conn_host_i is now connected
- conn_host_i  in  HOST_ADDR_WIDTH  host for connected_i
- disconnect_i  in  1  one-cycle pulse: the host on disc_host_i is closed
- disc_host_i  in  HOST_ADDR_WIDTH  host for disconnect_i
- msg_sent_i  in  1  pulse: a message was sent to sent_host_i
- sent_host_i  in  HOST_ADDR_WIDTH  host for msg_sent_i
- msg_rcvd_i  in  1  pulse: a valid message was received from rcvd_host_i
- rcvd_host_i  in  HOST_ADDR_WIDTH  host for msg_rcvd_i
- req_o  out  1  Heartbeat creation request
- req_host_o  out  HOST_ADDR_WIDTH  target host for req_o
- msg_type_o  out  4  equals HB_TYPE while req_o is high, otherwise 0
- grant_i  in  1  creation path accepted the request (start issued)
- done_i  in  1  creation path finished the message
- timeout_o  out  1  one-cycle timeout pulse
- timeout_host_o  out  HOST_ADDR_WIDTH  host that timed out; held until the next timeout
- busy_o  out  1  high in REQ and WAIT

Behaviour:
- Reset state:
  - All outputs are 0.
  - All hosts are inactive; all tx_cnt and rx_cnt are 0; no hosts are pending.
  - The prescaler is 0, the round-robin pointer is 0, and the FSM is IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when it wraps. The first tick occurs at cycle TICK_DIV after reset deasserts.
- Per-host counters (8-bit, saturating at 255), active hosts only:
  - On tick, tx_cnt and rx_cnt each increment by 1.
  - msg_sent_i for the host clears tx_cnt that cycle; this wins over tick.
  - msg_rcvd_i for the host clears rx_cnt that cycle; this wins over tick.
- connected_i:
  - Sets the host active and clears tx_cnt, rx_cnt and the host's pending flag.
  - Wins over every other same-cycle event for that host.
- disconnect_i:
  - Clears the host's active and pending flags; its counters freeze.
  - If connected_i and disconnect_i name the same host in the same cycle, connect wins.
- Pending flag: set when tx_cnt becomes equal to HB_INT while the host is active. The flag is not re-set while tx_cnt stays saturated above HB_INT; it is re-armed only when tx_cnt is cleared.
- Timeout:
  - Fires when rx_cnt becomes equal to RX_TIMEOUT on an active host.
  - timeout_o pulses for 1 cycle and timeout_host_o is loaded with that host. The host is deactivated and its pending flag is cleared.
  - If several hosts time out on the same tick, they are reported in ascending host index on consecutive cycles (the queue is a per-host flag vector).
- FSM:
  - IDLE:
    - If any host is pending, select the first pending host at or after the round-robin pointer, modulo N.
    - Register it on req_host_o, assert req_o, and move to REQ. req_o rises the cycle after the pending flag is set.
  - REQ:
    - Hold req_o, req_host_o and msg_type_o stable until grant_i.
    - On grant_i: deassert req_o, clear that host's pending flag, and move to WAIT.
    - If the selected host is disconnected or times out while in REQ: drop req_o and return to IDLE without advancing the pointer.
  - WAIT:
    - Wait for done_i. On done_i, clear tx_cnt of the served host (unless it is inactive), set the pointer to served host + 1 (wrapping), and return to IDLE.
    - A disconnect during WAIT does not abort the transaction.
  - grant_i or done_i outside REQ/WAIT respectively is ignored.
- Reset asserted mid-transaction returns every register to its reset state on the next edge; no done_i is awaited.

Test Plan:
All scenarios use TICK_DIV=4, HB_INT=3, RX_TIMEOUT=5, HOST_ADDR_WIDTH=2.
- Connect host 2, then send and receive nothing → req_o=1 with req_host_o=2 and msg_type_o=HB_TYPE, 1 cycle after the third tick; grant at +2 cycles and done at +5 cycles → req_o=0, busy_o=0 after done, tx_cnt(2)=0.
- Connect host 1; pulse msg_sent_i for host 1 every 8 cycles → req_o never asserts over 200 cycles.
- Connect hosts 0, 1 and 3 on the same cycle; never grant until all three are pending; then grant and finish each → served in order 0, 1, 3, then the pointer wraps back to 0.
- Connect host 3 with no msg_rcvd_i → timeout_o pulses exactly once on the fifth tick with timeout_host_o=3; host 3 then generates no further requests.
- Host 2 is in REQ and disconnect_i for host 2 arrives before grant_i → req_o drops the next cycle, FSM is IDLE, and no done_i is expected.
- Host 0 is in WAIT and rst is asserted for 1 cycle → all outputs are 0 the next cycle; with no further connect, req_o stays 0.

Source files
------------

// File: rtl/heartbeat_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_scheduler
// Description : Per-host FIX session timer. Counts ticks since the last send
//               and receive for each host, requests Heartbeats round-robin
//               (one outstanding at a time) and reports receive timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_scheduler #(
  parameter int         HOST_ADDR_WIDTH = 2,
  parameter int         TICK_DIV        = 1000,
  parameter int         HB_INT          = 30,
  parameter int         RX_TIMEOUT      = 36,
  parameter logic [3:0] HB_TYPE         = 4'd0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       connected_i,
  input  logic [HOST_ADDR_WIDTH-1:0] conn_host_i,
  input  logic                       disconnect_i,
  input  logic [HOST_ADDR_WIDTH-1:0] disc_host_i,
  input  logic                       msg_sent_i,
  input  logic [HOST_ADDR_WIDTH-1:0] sent_host_i,
  input  logic                       msg_rcvd_i,
  input  logic [HOST_ADDR_WIDTH-1:0] rcvd_host_i,
  output logic                       req_o,
  output logic [HOST_ADDR_WIDTH-1:0] req_host_o,
  output logic [3:0]                 msg_type_o,
  input  logic                       grant_i,
  input  logic                       done_i,
  output logic                       timeout_o,
  output logic [HOST_ADDR_WIDTH-1:0] timeout_host_o,
  output logic                       busy_o
);

  localparam int N     = 2 ** HOST_ADDR_WIDTH;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0]       C_HB      = 8'(HB_INT);
  localparam logic [7:0]       C_RX      = 8'(RX_TIMEOUT);
  localparam logic [7:0]       C_SAT     = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Shared signals
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0]           r_pre;
  logic                       w_tick;

  state_t                     r_state;
  state_t                     w_state_n;
  logic [HOST_ADDR_WIDTH-1:0] r_sel;
  logic [HOST_ADDR_WIDTH-1:0] w_sel_n;
  logic [HOST_ADDR_WIDTH-1:0] r_ptr;
  logic [HOST_ADDR_WIDTH-1:0] w_ptr_n;
  logic                       w_grant_fire;
  logic                       w_done_fire;
  logic                       w_found;
  logic [HOST_ADDR_WIDTH-1:0] w_pick;
  logic [HOST_ADDR_WIDTH-1:0] w_idx;

  logic [N-1:0]               w_act_n_vec;
  logic [N-1:0]               w_pend_vec;
  logic [N-1:0]               w_tof_vec;

  logic                       w_to_fire;
  logic [HOST_ADDR_WIDTH-1:0] w_to_host;
  logic                       r_to;
  logic [HOST_ADDR_WIDTH-1:0] r_to_host;

  // --------------------------------------------------------------------------
  // Prescaler: one logical second every TICK_DIV clocks
  // --------------------------------------------------------------------------
  assign w_tick = (r_pre == C_PRE_MAX);

  // Free-running prescaler that wraps on the tick cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Transaction events that touch per-host state
  assign w_done_fire  = (r_state == ST_WAIT) && done_i;
  // A host lost this very cycle (disconnect or timeout) beats a grant
  assign w_grant_fire = (r_state == ST_REQ) && w_act_n_vec[r_sel] && grant_i;

  // --------------------------------------------------------------------------
  // Per-host session state
  // --------------------------------------------------------------------------
  for (genvar h = 0; h < N; h++) begin : g_host
    logic       w_conn;
    logic       w_disc;
    logic       w_sent;
    logic       w_rcvd;
    logic       w_srv_clr;
    logic       w_grant_clr;
    logic       w_tof_clr;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] w_tx_n;
    logic [7:0] w_rx_n;
    logic [7:0] w_tx_inc;
    logic [7:0] w_rx_inc;
    logic       r_act;
    logic       r_pend;
    logic       r_tof;
    logic       w_act_n;
    logic       w_pend_n;
    logic       w_tof_n;

    assign w_conn      = connected_i  && (conn_host_i == HOST_ADDR_WIDTH'(h));
    assign w_disc      = disconnect_i && (disc_host_i == HOST_ADDR_WIDTH'(h));
    assign w_sent      = msg_sent_i   && (sent_host_i == HOST_ADDR_WIDTH'(h));
    assign w_rcvd      = msg_rcvd_i   && (rcvd_host_i == HOST_ADDR_WIDTH'(h));
    assign w_srv_clr   = w_done_fire  && (r_sel == HOST_ADDR_WIDTH'(h));
    assign w_grant_clr = w_grant_fire && (r_sel == HOST_ADDR_WIDTH'(h));
    assign w_tof_clr   = w_to_fire    && (w_to_host == HOST_ADDR_WIDTH'(h));

    // Counters saturate so a long-idle host never wraps back into range
    assign w_tx_inc = (r_tx == C_SAT) ? r_tx : r_tx + 8'd1;
    assign w_rx_inc = (r_rx == C_SAT) ? r_rx : r_rx + 8'd1;

    // Next-state of one host: connect > disconnect > counting on active hosts
    always_comb begin
      w_act_n  = r_act;
      w_tx_n   = r_tx;
      w_rx_n   = r_rx;
      w_pend_n = r_pend;
      w_tof_n  = r_tof;
      if (w_conn) begin
        w_act_n  = 1'b1;
        w_tx_n   = 8'd0;
        w_rx_n   = 8'd0;
        w_pend_n = 1'b0;
        w_tof_n  = 1'b0;
      end else if (w_disc) begin
        w_act_n  = 1'b0;
        w_pend_n = 1'b0;
      end else if (r_act) begin
        if (w_sent || w_srv_clr) begin
          w_tx_n = 8'd0;
        end else if (w_tick) begin
          w_tx_n = w_tx_inc;
        end
        if (w_rcvd) begin
          w_rx_n = 8'd0;
        end else if (w_tick) begin
          w_rx_n = w_rx_inc;
        end
        // Edge-detect on the threshold so saturation never re-triggers
        if ((w_rx_n == C_RX) && (r_rx != C_RX)) begin
          w_tof_n  = 1'b1;
          w_act_n  = 1'b0;
          w_pend_n = 1'b0;
        end else if ((w_tx_n == C_HB) && (r_tx != C_HB)) begin
          w_pend_n = 1'b1;
        end
      end
    end

    // Host registers; grant and timeout-report consume the flags
    always_ff @(posedge clk) begin
      if (rst) begin
        r_act  <= 1'b0;
        r_tx   <= 8'd0;
        r_rx   <= 8'd0;
        r_pend <= 1'b0;
        r_tof  <= 1'b0;
      end else begin
        r_act  <= w_act_n;
        r_tx   <= w_tx_n;
        r_rx   <= w_rx_n;
        r_pend <= w_pend_n && !w_grant_clr;
        r_tof  <= w_tof_n && !w_tof_clr;
      end
    end

    assign w_act_n_vec[h] = w_act_n;
    assign w_pend_vec[h]  = r_pend;
    assign w_tof_vec[h]   = r_tof;
  end

  // --------------------------------------------------------------------------
  // Timeout reporting: lowest-index flagged host first, one per cycle
  // --------------------------------------------------------------------------
  assign w_to_fire = |w_tof_vec;

  // Priority pick of the lowest flagged host
  always_comb begin
    w_to_host = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_tof_vec[i]) begin
        w_to_host = HOST_ADDR_WIDTH'(i);
      end
    end
  end

  // Registered pulse; the reported host is held until the next timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to      <= 1'b0;
      r_to_host <= '0;
    end else begin
      r_to <= w_to_fire;
      if (w_to_fire) begin
        r_to_host <= w_to_host;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------------
  // Round-robin search plus next-state decode
  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_found   = 1'b0;
    w_pick    = r_ptr;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = r_ptr + HOST_ADDR_WIDTH'(k);
      if (!w_found && w_pend_vec[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_n = ST_REQ;
          w_sel_n   = w_pick;
        end
      end
      ST_REQ: begin
        // Abandon without moving the pointer if the target went away
        if (!w_act_n_vec[r_sel]) begin
          w_state_n = ST_IDLE;
        end else if (grant_i) begin
          w_state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_i) begin
          w_state_n = ST_IDLE;
          w_ptr_n   = r_sel + HOST_ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state, selected host and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_n;
      r_sel   <= w_sel_n;
      r_ptr   <= w_ptr_n;
    end
  end

  assign req_o          = (r_state == ST_REQ);
  assign req_host_o     = r_sel;
  assign msg_type_o     = (r_state == ST_REQ) ? HB_TYPE : 4'd0;
  assign busy_o         = (r_state != ST_IDLE);
  assign timeout_o      = r_to;
  assign timeout_host_o = r_to_host;

endmodule
`default_nettype wire
